hamming_secded_dnc: RTL and testbench

HAMMING_SECDED_DNC -- requirements
Module: hamming_secded_dnc

---
 rtl/hamming_secded_dnc.sv | 175 +++++++++++++++++
 tb/tb_hamming_secded_dnc.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_dnc.sv
// SECDED Hamming decoder with a 1- or 2-deep valid/ready pipeline and
// saturating corrected/uncorrectable event counters.
module hamming_secded_dnc #(
    parameter int DATA_W = 32,
    parameter int PAR_W  = 7,
    parameter int LAT    = 2,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_pattern,
    input  logic [PAR_W-1:0]  i_parity,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_pattern,
    output logic [PAR_W-2:0]  o_syndrome,
    output logic [1:0]        o_err_type,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_cnt_ce,
    output logic [CNT_W-1:0]  o_cnt_ue,
    output logic              o_ue_sticky
);

    localparam int SW = PAR_W - 1;
    localparam int N  = DATA_W + PAR_W - 1;
    localparam logic [SW-1:0] N_S = SW'(N);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CORR = 2'b01;
    localparam logic [1:0] ERR_UNC  = 2'b10;
    localparam logic [1:0] ERR_CHK  = 2'b11;

    logic              rdy_q;
    logic              out_adv;
    logic              out_vld_nxt;
    logic              hs_out;
    logic [DATA_W-1:0] src_pat;
    logic [PAR_W-1:0]  src_par;

    // o_ready stays low for one cycle after reset release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rdy_q <= 1'b0;
        else          rdy_q <= 1'b1;
    end

    assign out_adv = i_en && (!o_valid || i_ready);
    assign hs_out  = i_en && o_valid && i_ready;

    generate
        if (LAT == 1) begin : g_lat1
            assign o_ready     = out_adv && rdy_q;
            assign out_vld_nxt = o_ready && i_valid;
            assign src_pat     = i_pattern;
            assign src_par     = i_parity;
        end else begin : g_lat2
            logic              s1_valid;
            logic [DATA_W-1:0] s1_pat;
            logic [PAR_W-1:0]  s1_par;

            assign o_ready     = i_en && rdy_q && (!s1_valid || out_adv);
            assign out_vld_nxt = s1_valid;
            assign src_pat     = s1_pat;
            assign src_par     = s1_par;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    s1_valid <= 1'b0;
                    s1_pat   <= '0;
                    s1_par   <= '0;
                end else if (o_ready) begin
                    s1_valid <= i_valid;
                    if (i_valid) begin
                        s1_pat <= i_pattern;
                        s1_par <= i_parity;
                    end
                end else if (out_adv) begin
                    s1_valid <= 1'b0;
                end
            end
        end
    endgenerate

    logic [SW-1:0]     dec_syn;
    logic              dec_p;
    logic [1:0]        dec_err;
    logic [DATA_W-1:0] dec_pat;
    logic [DATA_W-1:0] sh_pat;
    logic [PAR_W-1:0]  sh_par;
    logic [DATA_W-1:0] dmask;

    // Walk codeword positions, consuming check bits at powers of two and data bits elsewhere
    always_comb begin
        dec_syn = '0;
        dec_p   = (^src_pat) ^ (^src_par);
        dec_err = ERR_NONE;
        dec_pat = src_pat;
        sh_pat  = src_pat;
        sh_par  = src_par;
        dmask   = '0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) == 0) begin
                if (sh_par[0]) dec_syn = dec_syn ^ SW'(pos);
                sh_par = sh_par >> 1;
            end else begin
                if (sh_pat[0]) dec_syn = dec_syn ^ SW'(pos);
                sh_pat = sh_pat >> 1;
            end
        end

        if (dec_syn == '0)                              dec_err = dec_p ? ERR_CHK : ERR_NONE;
        else if (!dec_p)                                dec_err = ERR_UNC;
        else if ((dec_syn & (dec_syn - 1'b1)) == '0)    dec_err = ERR_CHK;
        else if (dec_syn > N_S)                         dec_err = ERR_UNC;
        else                                            dec_err = ERR_CORR;

        dmask = DATA_W'(1);
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (dec_err == ERR_CORR && SW'(pos) == dec_syn) dec_pat = dec_pat ^ dmask;
                dmask = dmask << 1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_pattern  <= '0;
            o_syndrome <= '0;
            o_err_type <= ERR_NONE;
        end else if (out_adv) begin
            o_valid <= out_vld_nxt;
            if (out_vld_nxt) begin
                o_pattern  <= dec_pat;
                o_syndrome <= dec_syn;
                o_err_type <= dec_err;
            end
        end
    end

    logic [CNT_W-1:0] ce_nxt;
    logic [CNT_W-1:0] ue_nxt;
    logic             sticky_nxt;

    // Clear wins first, then a same-cycle event is still counted
    always_comb begin
        ce_nxt     = i_cnt_clr ? '0 : o_cnt_ce;
        ue_nxt     = i_cnt_clr ? '0 : o_cnt_ue;
        sticky_nxt = i_cnt_clr ? 1'b0 : o_ue_sticky;
        if (hs_out) begin
            if ((o_err_type == ERR_CORR || o_err_type == ERR_CHK) && ce_nxt != '1)
                ce_nxt = ce_nxt + CNT_W'(1);
            if (o_err_type == ERR_UNC) begin
                if (ue_nxt != '1) ue_nxt = ue_nxt + CNT_W'(1);
                sticky_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt_ce    <= '0;
            o_cnt_ue    <= '0;
            o_ue_sticky <= 1'b0;
        end else begin
            o_cnt_ce    <= ce_nxt;
            o_cnt_ue    <= ue_nxt;
            o_ue_sticky <= sticky_nxt;
        end
    end

endmodule

// File: tb/tb_hamming_secded_dnc.sv
// Bench for hamming_secded_dnc (8 data bits, 5 parity bits, 2 stages, 2-bit counters):
// directed cases, a stall/saturation stream, mid-flight reset and a randomized run.
module tb_hamming_secded_dnc;

    localparam int DW = 8;
    localparam int PW = 5;
    localparam int CW = 2;
    localparam int NP = 12;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_en = 1'b1;
    logic [DW-1:0] i_pattern = '0;
    logic [PW-1:0] i_parity = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] o_pattern;
    logic [PW-2:0] o_syndrome;
    logic [1:0]    o_err_type;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic          i_cnt_clr = 1'b0;
    logic [CW-1:0] o_cnt_ce;
    logic [CW-1:0] o_cnt_ue;
    logic          o_ue_sticky;

    hamming_secded_dnc #(.DATA_W(DW), .PAR_W(PW), .LAT(2), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
        .i_pattern(i_pattern), .i_parity(i_parity),
        .i_valid(i_valid), .o_ready(o_ready),
        .o_pattern(o_pattern), .o_syndrome(o_syndrome), .o_err_type(o_err_type),
        .o_valid(o_valid), .i_ready(i_ready),
        .i_cnt_clr(i_cnt_clr), .o_cnt_ce(o_cnt_ce), .o_cnt_ue(o_cnt_ue),
        .o_ue_sticky(o_ue_sticky)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0] pat;
        logic [PW-2:0] syn;
        logic [1:0]    err;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   total = 0;
    int   npass = 0;
    int   m_ce = 0, m_ue = 0;
    logic m_sticky = 1'b0;
    logic last_in_hs = 1'b0;
    logic hold_prev = 1'b0;
    logic [DW-1:0] prev_pat;
    logic [PW-2:0] prev_syn;
    logic [1:0]    prev_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic bit is_pow2(input int v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int data_idx(input int pos);
        int c = 0;
        for (int p = 1; p < pos; p++) if (!is_pow2(p)) c++;
        return c;
    endfunction

    // Check bits = XOR of the positions holding a 1 data bit; MSB makes total parity even
    function automatic logic [PW-1:0] encode(input logic [DW-1:0] d);
        logic [PW-2:0] c = '0;
        logic [DW-1:0] t = d;
        for (int pos = 1; pos <= NP; pos++) begin
            if (!is_pow2(pos)) begin
                if (t[0]) c = c ^ 4'(pos);
                t = t >> 1;
            end
        end
        return {(^d) ^ (^c), c};
    endfunction

    task automatic flip(input int qp, inout logic [DW-1:0] pat, inout logic [PW-1:0] par);
        if (qp == 0) par = par ^ 5'b10000;
        else if (is_pow2(qp)) begin
            for (int k = 0; k < 4; k++) if (qp == (1 << k)) par = par ^ (5'(1) << k);
        end else pat = pat ^ (8'(1) << data_idx(qp));
    endtask

    // Expected outcome follows from which codeword positions were flipped (0 = overall parity)
    task automatic make_word(input logic [DW-1:0] d, input int nfl, input int q1, input int q2);
        logic [DW-1:0] pat = d;
        logic [PW-1:0] par = encode(d);
        if (nfl >= 1) flip(q1, pat, par);
        if (nfl >= 2) flip(q2, pat, par);
        i_pattern = pat;
        i_parity  = par;
        if (nfl == 0)      begin cur.pat = d;   cur.syn = '0;         cur.err = 2'b00; end
        else if (nfl == 1) begin
            cur.pat = d;
            cur.syn = 4'(q1);
            cur.err = (q1 == 0 || is_pow2(q1)) ? 2'b11 : 2'b01;
        end else           begin cur.pat = pat; cur.syn = 4'(q1 ^ q2); cur.err = 2'b10; end
    endtask

    task automatic rand_word();
        int nfl = $urandom_range(0, 2);
        int q1 = $urandom_range(0, NP);
        int q2 = $urandom_range(0, NP);
        while (q2 == q1) q2 = $urandom_range(0, NP);
        make_word(8'($urandom), nfl, q1, q2);
    endtask

    task automatic model_reset();
        q.delete();
        m_ce = 0; m_ue = 0; m_sticky = 1'b0;
        hold_prev = 1'b0;
    endtask

    // One clock cycle: inputs already driven at the falling edge
    task automatic tick();
        logic in_hs, out_hs;
        exp_t e;
        #1;
        chk("cnt_ce", 32'(o_cnt_ce), 32'(m_ce));
        chk("cnt_ue", 32'(o_cnt_ue), 32'(m_ue));
        chk("ue_sticky", 32'(o_ue_sticky), 32'(m_sticky));
        if (hold_prev) begin
            chk("hold_valid", 32'(o_valid), 1);
            chk("hold_pattern", 32'(o_pattern), 32'(prev_pat));
            chk("hold_syndrome", 32'(o_syndrome), 32'(prev_syn));
            chk("hold_err", 32'(o_err_type), 32'(prev_err));
        end
        in_hs  = i_valid && o_ready;
        out_hs = i_en && o_valid && i_ready;
        if (i_cnt_clr) begin m_ce = 0; m_ue = 0; m_sticky = 1'b0; end
        if (out_hs) begin
            chk("scoreboard_has_word", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_pattern", 32'(o_pattern), 32'(e.pat));
                chk("out_syndrome", 32'(o_syndrome), 32'(e.syn));
                chk("out_err", 32'(o_err_type), 32'(e.err));
                if (e.err == 2'b01 || e.err == 2'b11) m_ce = (m_ce < 3) ? m_ce + 1 : 3;
                if (e.err == 2'b10) begin m_ue = (m_ue < 3) ? m_ue + 1 : 3; m_sticky = 1'b1; end
            end
        end
        hold_prev = o_valid && !out_hs;
        prev_pat = o_pattern; prev_syn = o_syndrome; prev_err = o_err_type;
        if (in_hs) q.push_back(cur);
        last_in_hs = in_hs;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic send(input logic [DW-1:0] d, input int nfl, input int q1, input int q2,
                        input bit clr_at_out);
        make_word(d, nfl, q1, q2);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        i_cnt_clr = clr_at_out;
        tick();
        i_cnt_clr = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        i_valid = 1'b0;
        for (int n = 0; n < 40 && q.size() > 0; n++) tick();
        chk(tag, 32'(q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, cyc;
        int dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};

        #12;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_pattern", 32'(o_pattern), 0);
        chk("rst_syndrome", 32'(o_syndrome), 0);
        chk("rst_err", 32'(o_err_type), 0);
        chk("rst_cnt_ce", 32'(o_cnt_ce), 0);
        chk("rst_cnt_ue", 32'(o_cnt_ue), 0);
        chk("rst_sticky", 32'(o_ue_sticky), 0);
        chk("rst_ready", 32'(o_ready), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 chk("ready_first_cycle", 32'(o_ready), 0);
        @(posedge i_clk);
        #1 chk("ready_after", 32'(o_ready), 1);
        @(negedge i_clk);

        // clean 0xA5, two-cycle latency
        make_word(8'hA5, 0, 0, 0);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("lat_not_early", 32'(o_valid), 0);
        tick();
        chk("lat_valid", 32'(o_valid), 1);
        chk("clean_pattern", 32'(o_pattern), 32'hA5);
        tick();
        tick();

        send(8'h00, 1, 3, 0, 1'b0);
        chk("single_cnt_ce", 32'(o_cnt_ce), 1);
        send(8'h00, 2, 3, 5, 1'b0);
        chk("double_sticky", 32'(o_ue_sticky), 1);
        chk("double_cnt_ue", 32'(o_cnt_ue), 1);
        send(8'h3C, 1, 0, 0, 1'b0);
        chk("ovp_cnt_ce", 32'(o_cnt_ce), 2);

        // clear coinciding with a corrected-word handshake counts it
        send(8'h5E, 1, 6, 0, 1'b1);
        chk("clr_priority_ce", 32'(o_cnt_ce), 1);
        chk("clr_priority_sticky", 32'(o_ue_sticky), 0);

        i_cnt_clr = 1'b1;
        tick();
        i_cnt_clr = 1'b0;

        // stream with a 3-cycle downstream stall; first 5 words carry single data errors
        idx = 0; cyc = 0;
        make_word(8'($urandom), 1, dpos[0], 0);
        while (idx < 10 && cyc < 100) begin
            i_valid = 1'b1;
            i_ready = !(cyc >= 4 && cyc < 7);
            if (cyc >= 4 && cyc < 7) begin
                #1 chk("ready_low_full", 32'(o_ready), 0);
            end
            tick();
            if (last_in_hs) begin
                idx++;
                if (idx < 5) make_word(8'($urandom), 1, dpos[$urandom_range(0, 7)], 0);
                else         make_word(8'($urandom), 0, 0, 0);
            end
            cyc++;
        end
        chk("stream_accepted", 32'(idx), 10);
        i_ready = 1'b1;
        drain("stream_drain");
        chk("ce_saturated", 32'(o_cnt_ce), 3);

        // reset with two words in flight
        i_ready = 1'b0;
        idx = 0;
        make_word(8'h11, 0, 0, 0);
        for (int n = 0; n < 10 && idx < 2; n++) begin
            i_valid = 1'b1;
            tick();
            if (last_in_hs) begin idx++; make_word(8'h22, 0, 0, 0); end
        end
        chk("inflight_two", 32'(idx), 2);
        i_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(o_valid), 0);
        chk("midrst_ready", 32'(o_ready), 0);
        chk("midrst_cnt_ce", 32'(o_cnt_ce), 0);
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("no_stale", 32'(o_valid), 0);
        end

        // randomized traffic with enable gaps, stalls and occasional clears
        rand_word();
        for (int n = 0; n < 400; n++) begin
            i_en      = ($urandom_range(0, 9) != 0);
            i_valid   = $urandom_range(0, 3) != 0;
            i_ready   = $urandom_range(0, 9) < 7;
            i_cnt_clr = $urandom_range(0, 39) == 0;
            tick();
            if (last_in_hs) rand_word();
        end
        i_en = 1'b1;
        i_ready = 1'b1;
        i_cnt_clr = 1'b0;
        drain("random_drain");

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end

endmodule
